led_blink_array: RTL and testbench
==================================

LED_BLINK_ARRAY -- requirements
Module: led_blink_array

Interface
REQ-001 Parameter CH_NUM, default 4: number of independent LED channels, range 1..16.
REQ-002 Parameter CNT_W, default 25: width of each channel's period register and tick counter.
REQ-003 Parameter PRE_MAX, default 49_999: prescaler terminal count; one tick every PRE_MAX+1 clocks.
REQ-004 Parameter DEF_PERIOD, default 499: reset value of every channel period register, in ticks.
REQ-005 Port sys_clk, input, 1: single clock; all logic is posedge sys_clk.
REQ-006 Port sys_rst_n, input, 1: synchronous, active-low reset.
REQ-007 Port run, input, 1: global enable; low freezes the prescaler, channel counters and LEDs.
REQ-008 Port cfg_wr, input, 1: one-cycle configuration write strobe.
REQ-009 Port cfg_addr, input, $clog2(CH_NUM) (min 1): target channel index.
REQ-010 Port cfg_period, input, CNT_W: new period value in ticks, minus one.
REQ-011 Port cfg_mode, input, 2: new channel mode; 0 TOGGLE, 1 PULSE, 2 ON, 3 OFF.
REQ-012 Port led_out, output, CH_NUM: registered LED drive, one bit per channel.
REQ-013 Port wrap_pulse, output, CH_NUM: one-clock strobe per channel when its tick counter wraps.

Function
REQ-014 The prescaler shall count 0..PRE_MAX while run=1, then wrap to 0; tick=1 for exactly the clock where count==PRE_MAX and run=1.
REQ-015 Each channel counter shall advance only on tick; on a tick with counter==period it shall return to 0 and assert that channel's wrap_pulse for one clock.
REQ-016 TOGGLE: led_out[i] shall invert on each wrap, giving a half-period of (PRE_MAX+1)*(period+1) clocks; period=0 toggles every tick.
REQ-017 PULSE: led_out[i] shall be 1 from the wrap until the next tick only, i.e. high for PRE_MAX+1 clocks every (period+1) ticks.
REQ-018 ON/OFF: led_out[i] shall be constant 1/0; the counter and wrap_pulse keep running.
REQ-019 cfg_wr with cfg_addr<CH_NUM shall, on the next clock edge, load the period and mode, clear that channel's counter, and set led_out[i] to 0 (ON: 1).
REQ-020 cfg_wr with cfg_addr>=CH_NUM shall be ignored with no state change.
REQ-021 A cfg_wr coinciding with a tick or wrap on the same channel shall take priority; that wrap_pulse shall not fire.
REQ-022 run=0 shall hold all counters and led_out; cfg_wr shall still be accepted; run rising shall resume from held state without an extra tick.
REQ-023 Counter comparison shall be equality on CNT_W bits; no counter shall exceed its period except transiently after a write of a smaller period, which REQ-019 prevents by clearing.

Reset
REQ-024 sys_rst_n=0 at a clock edge shall clear prescaler, all counters, led_out and wrap_pulse to 0, set all periods to DEF_PERIOD and all modes to TOGGLE.
REQ-025 Reset asserted mid-period shall take effect at the next edge irrespective of run or cfg_wr.

Configuration
REQ-026 With macro LED_BLINK_PWM_EN defined, an input pwm_duty [7:0] and an 8-bit free-running PWM counter shall be added; led_out[i] = channel state AND (pwm_cnt < pwm_duty); duty 0 gives off, 255 gives 255/256 on.
REQ-027 Without LED_BLINK_PWM_EN, the pwm_duty port and PWM counter shall be absent and led_out shall equal channel state directly.
REQ-028 The PWM counter shall reset to 0 and run regardless of run.

Structure
REQ-029 Package led_blink_pkg shall hold the mode encoding (MODE_TOGGLE, MODE_PULSE, MODE_ON, MODE_OFF) and the mode typedef.
REQ-030 The prescaler shall be a sub-module tick_gen (params PRE_MAX; ports sys_clk, sys_rst_n, run, tick).

Verification
REQ-031 PRE_MAX=3, reset then run=1, ch0 period 2 TOGGLE -> led_out[0] rises 12 clocks after reset release, falls 12 clocks later; wrap_pulse[0] high on those edges.
REQ-032 PRE_MAX=3, ch1 PULSE period 3 -> led_out[1] high 4 clocks every 16 clocks.
REQ-033 Write ch2 period 5 on the clock of its wrap -> no wrap_pulse[2], counter 0, next wrap 24 clocks later.
REQ-034 cfg_addr=CH_NUM with cfg_wr -> all periods, modes, led_out unchanged.
REQ-035 run=0 for 10 clocks mid-period -> led_out and wrap timing shifted by exactly 10 clocks.
REQ-036 LED_BLINK_PWM_EN, ch0 ON, pwm_duty=64 -> led_out[0] high 64 of every 256 clocks; pwm_duty=0 -> constant 0.

Source files
------------

// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - shared mode encoding and LED next-state helper for led_blink_array
//
// Purpose: channel mode typedef plus the per-channel LED update rule.
// Ports:   none (package).
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_ON     = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  // Next LED state on a tick. PULSE goes high on a wrap and drops on the
  // following non-wrapping tick, so it is high for one tick interval.
  function automatic logic led_next(mode_e mode, logic cur, logic wrap);
    logic nxt;
    nxt = cur;
    case (mode)
      MODE_TOGGLE: nxt = wrap ? ~cur : cur;
      MODE_PULSE:  nxt = wrap;
      MODE_ON:     nxt = 1'b1;
      MODE_OFF:    nxt = 1'b0;
      default:     nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_blink_tick_gen.sv
// rtl/led_blink_tick_gen.sv - prescaler producing one tick every PRE_MAX+1 running clocks
//
// Purpose: free-running prescaler gated by run.
// Ports:
//   sys_clk   - clock, posedge
//   sys_rst_n - synchronous active-low reset
//   run       - count enable; low freezes the count
//   tick      - high during the clock where count==PRE_MAX and run=1
module tick_gen #(
  parameter int  PRE_MAX = 49_999,
  localparam int PW      = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic run,
  output logic tick
);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == PW'(PRE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (run) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_array.sv
// rtl/led_blink_array.sv - array of independently configurable blinking LED channels
//
// Purpose: CH_NUM channels, each with a period register, tick counter and
//          mode (TOGGLE/PULSE/ON/OFF), all advanced by a shared prescaler.
// Optional feature: define LED_BLINK_PWM_EN to add pwm_duty and an 8-bit
//          free-running PWM counter that gates every LED output.
// Ports:
//   sys_clk    - clock, posedge
//   sys_rst_n  - synchronous active-low reset
//   run        - global enable for prescaler, counters and LEDs
//   cfg_wr     - one-cycle configuration write strobe
//   cfg_addr   - target channel index
//   cfg_period - new period in ticks, minus one
//   cfg_mode   - new mode (0 TOGGLE, 1 PULSE, 2 ON, 3 OFF)
//   pwm_duty   - PWM duty, 0..255 (LED_BLINK_PWM_EN only)
//   led_out    - LED drive, one bit per channel
//   wrap_pulse - one-clock strobe per channel on counter wrap
module led_blink_array
  import led_blink_pkg::*;
#(
  parameter int  CH_NUM     = 4,
  parameter int  CNT_W      = 25,
  parameter int  PRE_MAX    = 49_999,
  parameter int  DEF_PERIOD = 499,
  localparam int AW         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              run,
  input  logic              cfg_wr,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [1:0]        cfg_mode,
`ifdef LED_BLINK_PWM_EN
  input  logic [7:0]        pwm_duty,
`endif
  output logic [CH_NUM-1:0] led_out,
  output logic [CH_NUM-1:0] wrap_pulse
);

  logic tick;

  tick_gen #(
    .PRE_MAX(PRE_MAX)
  ) u_tick_gen (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .run      (run),
    .tick     (tick)
  );

  logic [CNT_W-1:0]  period_q [CH_NUM];
  logic [CNT_W-1:0]  period_d [CH_NUM];
  logic [CNT_W-1:0]  cnt_q    [CH_NUM];
  logic [CNT_W-1:0]  cnt_d    [CH_NUM];
  mode_e             mode_q   [CH_NUM];
  mode_e             mode_d   [CH_NUM];
  logic [CH_NUM-1:0] state_q, state_d;
  logic [CH_NUM-1:0] wrap_q, wrap_d;

  // A configuration write on a channel wins over a coincident tick/wrap:
  // the counter restarts from 0 and no wrap strobe is produced. Addresses
  // beyond CH_NUM-1 match no channel and are therefore ignored.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      mode_d[i]   = mode_q[i];
      state_d[i]  = state_q[i];
      wrap_d[i]   = 1'b0;
      if (cfg_wr && (cfg_addr == AW'(i))) begin
        period_d[i] = cfg_period;
        mode_d[i]   = mode_e'(cfg_mode);
        cnt_d[i]    = '0;
        state_d[i]  = (mode_e'(cfg_mode) == MODE_ON);
      end else if (tick) begin
        if (cnt_q[i] == period_q[i]) begin
          cnt_d[i]  = '0;
          wrap_d[i] = 1'b1;
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        end
        state_d[i] = led_next(mode_q[i], state_q[i], wrap_d[i]);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        period_q[i] <= CNT_W'(DEF_PERIOD);
        cnt_q[i]    <= '0;
        mode_q[i]   <= MODE_TOGGLE;
      end
      state_q <= '0;
      wrap_q  <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
        mode_q[i]   <= mode_d[i];
      end
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end

  assign wrap_pulse = wrap_q;

`ifdef LED_BLINK_PWM_EN
  // PWM counter ignores run so dimming stays steady while blinking is frozen.
  logic [7:0] pwm_cnt_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
    end
  end

  assign led_out = state_q & {CH_NUM{pwm_cnt_q < pwm_duty}};
`else
  assign led_out = state_q;
`endif

endmodule

// File: tb/tb_led_blink_array.sv
// tb/tb_led_blink_array.sv - self-checking bench for led_blink_array
module tb_led_blink_array;
  import led_blink_pkg::*;

  localparam int CH_NUM     = 3;
  localparam int CNT_W      = 8;
  localparam int PRE_MAX    = 3;
  localparam int DEF_PERIOD = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       run;
  logic       cfg_wr;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_period;
  logic [1:0] cfg_mode;
`ifdef LED_BLINK_PWM_EN
  logic [7:0] pwm_duty;
`endif
  logic [2:0] led_out;
  logic [2:0] wrap_pulse;

  int n_vec = 0;
  int n_err = 0;

  led_blink_array #(
    .CH_NUM    (CH_NUM),
    .CNT_W     (CNT_W),
    .PRE_MAX   (PRE_MAX),
    .DEF_PERIOD(DEF_PERIOD)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .run       (run),
    .cfg_wr    (cfg_wr),
    .cfg_addr  (cfg_addr),
    .cfg_period(cfg_period),
    .cfg_mode  (cfg_mode),
`ifdef LED_BLINK_PWM_EN
    .pwm_duty  (pwm_duty),
`endif
    .led_out   (led_out),
    .wrap_pulse(wrap_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  // Period 2 TOGGLE with PRE_MAX 3: 12 running clocks per half period.
  function automatic logic tog_led(int a);
    return ((a / 12) % 2) == 1;
  endfunction

  function automatic logic tog_wrap(int a);
    return (a > 0) && ((a % 12) == 0);
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    run       = 1'b0;
    cfg_wr    = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic write_cfg(input logic [1:0] addr, input logic [7:0] per, input logic [1:0] mode);
    cfg_wr     = 1'b1;
    cfg_addr   = addr;
    cfg_period = per;
    cfg_mode   = mode;
    step();
    cfg_wr     = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; run = 1'b1; cfg_wr = 1'b0;
    cfg_addr = '0; cfg_period = '0; cfg_mode = '0;
    step();
    step();
    n_vec++;
    if (led_out !== 3'b000) begin
      n_err++; $display("FAIL reset_led: got %b expected %b", led_out, 3'b000);
    end
    n_vec++;
    if (wrap_pulse !== 3'b000) begin
      n_err++; $display("FAIL reset_wrap: got %b expected %b", wrap_pulse, 3'b000);
    end
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 13; k++) step();
    n_vec++;
    if (led_out !== 3'b111) begin
      n_err++; $display("FAIL pre_midreset_led: got %b expected %b", led_out, 3'b111);
    end
    // Reset must beat a simultaneous write and an active run.
    sys_rst_n = 1'b0; cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_period = 8'd7; cfg_mode = MODE_ON;
    step();
    n_vec++;
    if (led_out !== 3'b000) begin
      n_err++; $display("FAIL midreset_led: got %b expected %b", led_out, 3'b000);
    end
    cfg_wr = 1'b0;
  endtask

  task automatic test_toggle();
    apply_reset();
    run = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      n_vec++;
      if (led_out !== {3{tog_led(k)}}) begin
        n_err++; $display("FAIL toggle_led k=%0d: got %b expected %b", k, led_out, {3{tog_led(k)}});
      end
      n_vec++;
      if (wrap_pulse !== {3{tog_wrap(k)}}) begin
        n_err++; $display("FAIL toggle_wrap k=%0d: got %b expected %b", k, wrap_pulse, {3{tog_wrap(k)}});
      end
    end
  endtask

  task automatic test_pulse();
    logic [2:0] el, ew;
    apply_reset();
    write_cfg(2'd1, 8'd3, MODE_PULSE);
    run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      el = {tog_led(k), (k >= 16) && ((k % 16) < 4), tog_led(k)};
      ew = {tog_wrap(k), (k % 16) == 0, tog_wrap(k)};
      n_vec++;
      if (led_out !== el) begin
        n_err++; $display("FAIL pulse_led k=%0d: got %b expected %b", k, led_out, el);
      end
      n_vec++;
      if (wrap_pulse !== ew) begin
        n_err++; $display("FAIL pulse_wrap k=%0d: got %b expected %b", k, wrap_pulse, ew);
      end
    end
  endtask

  task automatic test_on_off();
    logic [2:0] el;
    apply_reset();
    write_cfg(2'd0, 8'd2, MODE_ON);
    n_vec++;
    if (led_out !== 3'b001) begin
      n_err++; $display("FAIL on_write_led: got %b expected %b", led_out, 3'b001);
    end
    write_cfg(2'd1, 8'd2, MODE_OFF);
    run = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      el = {tog_led(k), 1'b0, 1'b1};
      n_vec++;
      if (led_out !== el) begin
        n_err++; $display("FAIL onoff_led k=%0d: got %b expected %b", k, led_out, el);
      end
      n_vec++;
      if (wrap_pulse !== {3{tog_wrap(k)}}) begin
        n_err++; $display("FAIL onoff_wrap k=%0d: got %b expected %b", k, wrap_pulse, {3{tog_wrap(k)}});
      end
    end
  endtask

  task automatic test_cfg_on_wrap();
    logic [2:0] el, ew;
    apply_reset();
    run = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 12) begin
        cfg_wr = 1'b1; cfg_addr = 2'd2; cfg_period = 8'd5; cfg_mode = MODE_TOGGLE;
      end
      step();
      cfg_wr = 1'b0;
      el = {k >= 36, tog_led(k), tog_led(k)};
      ew = {k == 36, tog_wrap(k), tog_wrap(k)};
      n_vec++;
      if (led_out !== el) begin
        n_err++; $display("FAIL cfgwrap_led k=%0d: got %b expected %b", k, led_out, el);
      end
      n_vec++;
      if (wrap_pulse !== ew) begin
        n_err++; $display("FAIL cfgwrap_wrap k=%0d: got %b expected %b", k, wrap_pulse, ew);
      end
    end
  endtask

  task automatic test_bad_addr();
    apply_reset();
    write_cfg(2'd3, 8'd0, MODE_ON);
    n_vec++;
    if (led_out !== 3'b000) begin
      n_err++; $display("FAIL badaddr_led0: got %b expected %b", led_out, 3'b000);
    end
    run = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      n_vec++;
      if (led_out !== {3{tog_led(k)}}) begin
        n_err++; $display("FAIL badaddr_led k=%0d: got %b expected %b", k, led_out, {3{tog_led(k)}});
      end
      n_vec++;
      if (wrap_pulse !== {3{tog_wrap(k)}}) begin
        n_err++; $display("FAIL badaddr_wrap k=%0d: got %b expected %b", k, wrap_pulse, {3{tog_wrap(k)}});
      end
    end
  endtask

  task automatic test_run_hold();
    int   a;
    logic ew;
    apply_reset();
    a = 0;
    for (int k = 1; k <= 40; k++) begin
      run = !((k >= 7) && (k <= 16));
      step();
      if (run) a++;
      ew = run && tog_wrap(a);
      n_vec++;
      if (led_out !== {3{tog_led(a)}}) begin
        n_err++; $display("FAIL hold_led k=%0d: got %b expected %b", k, led_out, {3{tog_led(a)}});
      end
      n_vec++;
      if (wrap_pulse !== {3{ew}}) begin
        n_err++; $display("FAIL hold_wrap k=%0d: got %b expected %b", k, wrap_pulse, {3{ew}});
      end
    end
  endtask

`ifdef LED_BLINK_PWM_EN
  task automatic test_pwm();
    int hi;
    pwm_duty = 8'd64;
    apply_reset();
    write_cfg(2'd0, 8'd2, MODE_ON);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (led_out[0]) hi++;
    end
    n_vec++;
    if (hi !== 64) begin
      n_err++; $display("FAIL pwm_duty64: got %0d expected %0d", hi, 64);
    end
    pwm_duty = 8'd0;
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      step();
      if (led_out[0]) hi++;
    end
    n_vec++;
    if (hi !== 0) begin
      n_err++; $display("FAIL pwm_duty0: got %0d expected %0d", hi, 0);
    end
  endtask
`endif

  initial begin
`ifdef LED_BLINK_PWM_EN
    pwm_duty = 8'd255;
    test_reset();
    test_pwm();
`else
    test_reset();
    test_toggle();
    test_pulse();
    test_on_off();
    test_cfg_on_wrap();
    test_bad_addr();
    test_run_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
